// File: rtl/sdma_wdata_router.sv
// SDMA write-data router: one holding register steering beats to cache ports or AHB.
// Define SDMA_WDATA_ZEROIDLE_EN to zero every data output whose valid is low.
module sdma_wdata_router #(
  parameter int CDW    = 256,
  parameter int ADW    = 32,
  parameter int NCACHE = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [2:0]             i_inst_dstportid,
  input  logic                   i_wvalid,
  output logic                   o_wready,
  input  logic [CDW-1:0]         i_sdma_dportwdata,
  output logic [ADW-1:0]         o_sdma_ahbwdata,
  output logic                   o_ahb_wvalid,
  input  logic                   i_ahb_wready,
  output logic [NCACHE*CDW-1:0]  o_sdma_cwdata,
  output logic [NCACHE-1:0]      o_cache_wvalid,
  input  logic [NCACHE-1:0]      i_cache_wready,
  output logic                   o_route_err,
  output logic                   o_busy
);

  localparam int RATIO = CDW / ADW;
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  typedef enum logic [1:0] {IDLE, CACHE, AHB} state_t;

  state_t                     state;
  logic [RATIO-1:0][ADW-1:0]  hold;
  logic [1:0]                 port;
  logic [CW-1:0]              cnt;

  logic [3:0] crdy;
  logic       done;
  logic       accept;
  logic       to_ahb;
  logic       to_cache;

  always_comb begin
    crdy = '0;
    for (int i = 0; i < NCACHE; i++)
      crdy[i] = i_cache_wready[i];
  end

  // The current beat retires this cycle, so a new one may be taken.
  assign done = (state == CACHE && crdy[port]) ||
                (state == AHB && i_ahb_wready && cnt == LAST);

  assign o_wready = !i_rst && (state == IDLE || done);
  assign accept   = i_wvalid && o_wready;
  assign to_ahb   = i_inst_dstportid == 3'b000;
  assign to_cache = i_inst_dstportid[2] &&
                    ({1'b0, i_inst_dstportid[1:0]} < 3'(NCACHE));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      hold        <= '0;
      port        <= '0;
      cnt         <= '0;
      o_route_err <= 1'b0;
    end else begin
      o_route_err <= accept && !to_ahb && !to_cache;
      if (accept) begin
        cnt <= '0;
        unique case (1'b1)
          to_ahb: begin
            hold  <= i_sdma_dportwdata;
            state <= AHB;
          end
          to_cache: begin
            hold  <= i_sdma_dportwdata;
            port  <= i_inst_dstportid[1:0];
            state <= CACHE;
          end
          default: state <= IDLE;
        endcase
      end else if (done) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (state == AHB && i_ahb_wready) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_ahb_wvalid = state == AHB;
  assign o_busy       = state != IDLE;

  always_comb begin
    o_cache_wvalid = '0;
    for (int i = 0; i < NCACHE; i++)
      o_cache_wvalid[i] = (state == CACHE) && (port == 2'(i));
  end

  always_comb begin
    o_sdma_ahbwdata = hold[cnt];
    o_sdma_cwdata   = '0;
    for (int i = 0; i < NCACHE; i++)
      o_sdma_cwdata[i*CDW +: CDW] = hold;
`ifdef SDMA_WDATA_ZEROIDLE_EN
    if (!o_ahb_wvalid)
      o_sdma_ahbwdata = '0;
    for (int i = 0; i < NCACHE; i++)
      if (!o_cache_wvalid[i])
        o_sdma_cwdata[i*CDW +: CDW] = '0;
`else
`endif
  end

endmodule
